pixel_serial_driver: RTL

Parametrised successor to the bulk RGB serial driver. Accepts one packed pixel word per valid/ready handshake and emits it on a single-wire serial output, bit-interleaved across channels, framed by a start bit, an optional even-parity bit and configurable idle gap bits. Sits between the input-side pixel queues and the off-chip serial link. Runs entirely on one clock, with a programmable bit-period divider.

---
 rtl/pixel_serial_driver_if.sv | 23 ++
 rtl/pixel_serial_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_serial_driver_if.sv
// rtl/pixel_serial_driver_if.sv - pixel word handshake between the pixel queues and the serial driver
interface pixel_serial_driver_if #(
    parameter int W = 12
);
    logic [W-1:0] pix_data;
    logic         pix_sof;
    logic         pix_valid;
    logic         pix_ready;

    modport master (
        output pix_data,
        output pix_sof,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_sof,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/pixel_serial_driver.sv
// rtl/pixel_serial_driver.sv - single-wire pixel serialiser: start bit, channel-interleaved data, optional parity, idle gap
module pixel_serial_driver #(
    parameter int CH        = 3,
    parameter int BPC       = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY    = 0,
    parameter int GAP       = 1,
    parameter int DIV       = 1
) (
    input  logic                 clk,
    input  logic                 res_n,
    pixel_serial_driver_if.slave pix,
    output logic                 ser_out,
    output logic                 ser_mark,
    output logic                 busy
);
    localparam int W  = CH * BPC;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (CH  > 1) ? $clog2(CH)  : 1;
    localparam int BW = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CH - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BPC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t          r_state, w_state_n;
    logic [DW-1:0]   r_div,   w_div_n;
    logic [CW-1:0]   r_ch,    w_ch_n;
    logic [BW-1:0]   r_bit,   w_bit_n;
    logic [GW-1:0]   r_gap,   w_gap_n;
    logic [W-1:0]    r_hold,  w_hold_n;
    logic            r_sof,   w_sof_n;
    logic            r_ser,   w_ser_n;
    logic            r_mark,  w_mark_n;

    logic            w_tick;
    logic            w_last_data;
    logic            w_last;
    logic            w_accept;
    logic            w_data_bit;
    int              w_pos;
    int              w_idx;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_last_data = (r_ch == CH_LAST) && (r_bit == BIT_LAST);

    // The final cycle of a word's last bit period doubles as an accept slot,
    // which is what lets held-valid traffic run with no idle cycle between words.
    assign w_last = w_tick && (
                        ((r_state == S_GAP)  && (r_gap == GAP_LAST)) ||
                        ((r_state == S_PAR)  && (GAP == 0)) ||
                        ((r_state == S_DATA) && w_last_data && (PARITY == 0) && (GAP == 0)));

    assign pix.pix_ready = (r_state == S_IDLE) || w_last;
    assign w_accept      = pix.pix_valid && pix.pix_ready;

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_ch_n    = r_ch;
        w_bit_n   = r_bit;
        w_gap_n   = r_gap;
        w_hold_n  = r_hold;
        w_sof_n   = r_sof;

        if (w_accept) begin
            w_state_n = S_START;
            w_div_n   = '0;
            w_ch_n    = '0;
            w_bit_n   = '0;
            w_gap_n   = '0;
            w_hold_n  = pix.pix_data;
            w_sof_n   = pix.pix_sof;
        end else begin
            case (r_state)
                S_START: begin
                    if (w_tick) begin
                        w_div_n   = '0;
                        w_state_n = S_DATA;
                    end else begin
                        w_div_n = r_div + DW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        w_div_n = '0;
                        if (w_last_data) begin
                            w_ch_n    = '0;
                            w_bit_n   = '0;
                            w_state_n = (PARITY != 0) ? S_PAR :
                                        ((GAP > 0) ? S_GAP : S_IDLE);
                        end else if (r_ch == CH_LAST) begin
                            w_ch_n  = '0;
                            w_bit_n = r_bit + BW'(1);
                        end else begin
                            w_ch_n = r_ch + CW'(1);
                        end
                    end else begin
                        w_div_n = r_div + DW'(1);
                    end
                end
                S_PAR: begin
                    if (w_tick) begin
                        w_div_n   = '0;
                        w_gap_n   = '0;
                        w_state_n = (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        w_div_n = r_div + DW'(1);
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        w_div_n = '0;
                        if (r_gap == GAP_LAST) begin
                            w_gap_n   = '0;
                            w_state_n = S_IDLE;
                        end else begin
                            w_gap_n = r_gap + GW'(1);
                        end
                    end else begin
                        w_div_n = r_div + DW'(1);
                    end
                end
                default: begin
                    w_div_n = '0;
                end
            endcase
        end
    end

    // Channels interleave fastest: consecutive data bits walk across channels
    // at the same bit position before the position steps.
    always_comb begin
        w_pos = (MSB_FIRST != 0) ? (BPC - 1 - int'(w_bit_n)) : int'(w_bit_n);
        w_idx = (CH - 1 - int'(w_ch_n)) * BPC + w_pos;
        w_data_bit = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == w_idx) begin
                w_data_bit = w_hold_n[i];
            end
        end
    end

    always_comb begin
        w_ser_n  = 1'b0;
        w_mark_n = 1'b0;
        case (w_state_n)
            S_START: begin
                w_ser_n  = 1'b1;
                w_mark_n = w_sof_n;
            end
            S_DATA:  w_ser_n = w_data_bit;
            S_PAR:   w_ser_n = ^w_hold_n;
            default: w_ser_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_ch    <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_hold  <= '0;
            r_sof   <= 1'b0;
            r_ser   <= 1'b0;
            r_mark  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_ch    <= w_ch_n;
            r_bit   <= w_bit_n;
            r_gap   <= w_gap_n;
            r_hold  <= w_hold_n;
            r_sof   <= w_sof_n;
            r_ser   <= w_ser_n;
            r_mark  <= w_mark_n;
        end
    end

    assign ser_out  = r_ser;
    assign ser_mark = r_mark;
    assign busy     = (r_state != S_IDLE);
endmodule
